// File: rtl/rx_pingpong_buffer_ctrl_if.sv
// rtl/rx_pingpong_buffer_ctrl_if.sv - stream in/out and RAM port bundle for the RX ping-pong controller
interface rx_pingpong_buffer_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic                  iValid;
    logic [DATA_WIDTH-1:0] iData;
    logic                  oReady;
    logic                  oValid;
    logic [DATA_WIDTH-1:0] oData;
    logic                  oLast;
    logic                  iReady;
    logic                  oOverflow;
    logic                  oRamR_EN;
    logic                  oRamW_EN;
    logic [ADDR_WIDTH-1:0] oRamAddr;
    logic [DATA_WIDTH-1:0] oRamData;
    logic [DATA_WIDTH-1:0] iRamData;

    modport master (
        input  iValid, iData, iReady, iRamData,
        output oReady, oValid, oData, oLast, oOverflow,
               oRamR_EN, oRamW_EN, oRamAddr, oRamData
    );

    modport slave (
        output iValid, iData, iReady, iRamData,
        input  oReady, oValid, oData, oLast, oOverflow,
               oRamR_EN, oRamW_EN, oRamAddr, oRamData
    );
endinterface

// File: rtl/rx_pingpong_buffer_ctrl.sv
// rtl/rx_pingpong_buffer_ctrl.sv - ping-pong RAM controller, two half-banks; RX_BITREV_READ_EN selects bit-reversed drain order
module rx_pingpong_buffer_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                     iClk,
    input  logic                     iRst,
    rx_pingpong_buffer_ctrl_if.master bus
);
    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    logic                  wb_q, wb_d;
    logic [IDX_W-1:0]      wc_q, wc_d;
    logic                  rb_q, rb_d;
    logic [IDX_W-1:0]      rc_q, rc_d;
    logic [1:0]            full_q, full_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  ovf_q, ovf_d;

    logic                  ready;
    logic                  wr;
    logic                  rd;
    logic [IDX_W-1:0]      ridx;
    logic [ADDR_WIDTH-1:0] addr;

`ifdef RX_BITREV_READ_EN
    always_comb begin
        ridx = '0;
        for (int i = 0; i < IDX_W; i++) begin
            ridx[i] = rc_q[IDX_W-1-i];
        end
    end
`else
    assign ridx = rc_q;
`endif

    // Write owns the single RAM port; a read only issues when no write is taken.
    always_comb begin
        ready   = ~full_q[wb_q];
        wr      = bus.iValid & ready;
        rd      = full_q[rb_q] & ~wr & (~valid_q | bus.iReady);

        wb_d    = wb_q;
        wc_d    = wc_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        full_d  = full_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        addr    = '0;

        if (bus.iValid & ~ready) begin
            ovf_d = 1'b1;
        end

        if (wr) begin
            addr = {wb_q, wc_q};
            wc_d = wc_q + 1'b1;
            if (wc_q == LAST_IDX) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end else if (rd) begin
            addr = {rb_q, ridx};
        end

        if (rd) begin
            data_d  = bus.iRamData;
            valid_d = 1'b1;
            last_d  = (rc_q == LAST_IDX);
            rc_d    = rc_q + 1'b1;
            if (rc_q == LAST_IDX) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end
        end else if (valid_q & bus.iReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wb_q    <= 1'b0;
            wc_q    <= '0;
            rb_q    <= 1'b0;
            rc_q    <= '0;
            full_q  <= 2'b00;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            wc_q    <= wc_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.oReady    = ready;
    assign bus.oValid    = valid_q;
    assign bus.oData     = data_q;
    assign bus.oLast     = last_q;
    assign bus.oOverflow = ovf_q;
    assign bus.oRamW_EN  = wr;
    assign bus.oRamR_EN  = rd;
    assign bus.oRamAddr  = addr;
    assign bus.oRamData  = bus.iData;
endmodule

// File: tb/tb_rx_pingpong_buffer_ctrl.sv
// tb/tb_rx_pingpong_buffer_ctrl.sv - directed vector bench for rx_pingpong_buffer_ctrl
module tb_rx_pingpong_buffer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rx_pingpong_buffer_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

    rx_pingpong_buffer_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    logic [63:0] mem [32];
    always @(posedge clk) if (bus.oRamW_EN) mem[bus.oRamAddr] <= bus.oRamData;
    assign bus.iRamData = mem[bus.oRamAddr];

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        rdy;
        logic        e_ordy;
        logic        e_wen;
        logic        e_ren;
        logic [4:0]  e_addr;
        logic        e_ov;
        logic        chk_d;
        logic [63:0] e_d;
        logic        e_last;
    } vec_t;

    vec_t tbl [34];

    function automatic int idx(int k);
`ifdef RX_BITREV_READ_EN
        return {28'd0, k[0], k[1], k[2], k[3]};
`else
        return k;
`endif
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.iValid = 1'b0;
        bus.iReady = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_block(int base, logic rdy);
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.iValid = 1'b1;
            bus.iData  = 64'(base + i);
            bus.iReady = rdy;
        end
    endtask

    initial begin
        int          n;
        int          stall;
        logic [63:0] got [$];

        bus.iValid = 1'b0;
        bus.iData  = '0;
        bus.iReady = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ovalid", 64'(bus.oValid), 64'd0);
        chk("rst_odata", bus.oData, 64'd0);
        chk("rst_olast", 64'(bus.oLast), 64'd0);
        chk("rst_ovf", 64'(bus.oOverflow), 64'd0);
        chk("rst_oready", 64'(bus.oReady), 64'd1);
        chk("rst_ren", 64'(bus.oRamR_EN), 64'd0);
        chk("rst_wen", 64'(bus.oRamW_EN), 64'd0);
        chk("rst_addr", 64'(bus.oRamAddr), 64'd0);
        rst = 1'b0;

        // Linear/bitrev block through the table
        for (int i = 0; i < 34; i++) begin
            tbl[i] = '{v: 1'b0, d: 64'd0, rdy: 1'b1, e_ordy: 1'b1, e_wen: 1'b0, e_ren: 1'b0,
                       e_addr: 5'd0, e_ov: 1'b0, chk_d: 1'b0, e_d: 64'd0, e_last: 1'b0};
            if (i < 16) begin
                tbl[i].v = 1'b1;  tbl[i].d = 64'(i);
                tbl[i].e_wen = 1'b1; tbl[i].e_addr = 5'(i);
            end else if (i == 16) begin
                tbl[i].e_ren = 1'b1; tbl[i].e_addr = 5'(idx(0));
            end else if (i < 33) begin
                tbl[i].e_ov = 1'b1; tbl[i].chk_d = 1'b1;
                tbl[i].e_d = 64'(idx(i - 17)); tbl[i].e_last = (i == 32);
                tbl[i].e_ren = (i < 32);
                tbl[i].e_addr = (i < 32) ? 5'(idx(i - 16)) : 5'd0;
            end
        end
        for (int i = 0; i < 34; i++) begin
            tick();
            bus.iValid = tbl[i].v;
            bus.iData  = tbl[i].d;
            bus.iReady = tbl[i].rdy;
            #1;
            chk($sformatf("t%0d_oready", i), 64'(bus.oReady), 64'(tbl[i].e_ordy));
            chk($sformatf("t%0d_wen", i), 64'(bus.oRamW_EN), 64'(tbl[i].e_wen));
            chk($sformatf("t%0d_ren", i), 64'(bus.oRamR_EN), 64'(tbl[i].e_ren));
            chk($sformatf("t%0d_addr", i), 64'(bus.oRamAddr), 64'(tbl[i].e_addr));
            chk($sformatf("t%0d_ovalid", i), 64'(bus.oValid), 64'(tbl[i].e_ov));
            if (tbl[i].v) chk($sformatf("t%0d_wdata", i), bus.oRamData, tbl[i].d);
            if (tbl[i].chk_d) begin
                chk($sformatf("t%0d_odata", i), bus.oData, tbl[i].e_d);
                chk($sformatf("t%0d_olast", i), 64'(bus.oLast), 64'(tbl[i].e_last));
            end
        end

        // Output stall of 3 cycles while word index 4 is presented
        do_reset();
        wr_block(0, 1'b1);
        n = 0;
        stall = 0;
        for (int c = 0; c < 100 && n < 16; c++) begin
            tick();
            bus.iValid = 1'b0;
            bus.iReady = !(bus.oValid && n == 4 && stall < 3);
            #1;
            if (!bus.iReady) begin
                chk("stall_odata", bus.oData, 64'(idx(4)));
                chk("stall_ren", 64'(bus.oRamR_EN), 64'd0);
                stall++;
            end else if (bus.oValid) begin
                chk($sformatf("stall_out%0d", n), bus.oData, 64'(idx(n)));
                chk($sformatf("stall_last%0d", n), 64'(bus.oLast), 64'(n == 15));
                n++;
            end
        end
        chk("stall_count", 64'(stall), 64'd3);
        chk("stall_words", 64'(n), 64'd16);

        // Fill both banks with iReady=0, overflow, then drain
        do_reset();
        for (int i = 0; i < 32; i++) begin
            tick();
            bus.iValid = 1'b1;
            bus.iData  = 64'(i);
            bus.iReady = 1'b0;
            #1;
            chk($sformatf("fill%0d_wen", i), 64'(bus.oRamW_EN), 64'd1);
            chk($sformatf("fill%0d_ren", i), 64'(bus.oRamR_EN), 64'd0);
        end
        tick();
        bus.iData = 64'd999;
        #1;
        chk("full_oready", 64'(bus.oReady), 64'd0);
        chk("full_wen", 64'(bus.oRamW_EN), 64'd0);
        chk("full_ren", 64'(bus.oRamR_EN), 64'd1);
        tick();
        bus.iValid = 1'b0;
        #1;
        chk("ovf_set", 64'(bus.oOverflow), 64'd1);
        chk("ovf_hold_valid", 64'(bus.oValid), 64'd1);
        chk("ovf_hold_data", bus.oData, 64'(idx(0)));
        chk("ovf_hold_ren", 64'(bus.oRamR_EN), 64'd0);
        got.delete();
        for (int c = 0; c < 200 && got.size() < 32; c++) begin
            tick();
            bus.iValid = 1'b0;
            bus.iReady = 1'b1;
            #1;
            if (bus.oRamR_EN && bus.oRamW_EN) chk("drain_excl", 64'd1, 64'd0);
            if (bus.oValid) got.push_back(bus.oData);
        end
        chk("drain_count", 64'(got.size()), 64'd32);
        for (int k = 0; k < 32 && k < got.size(); k++) begin
            chk($sformatf("drain%0d", k), got[k], 64'((k < 16) ? idx(k) : 16 + idx(k - 16)));
        end

        // Reset in the middle of draining
        do_reset();
        chk("pre_rst_ovf_cleared_by_do_reset", 64'(bus.oOverflow), 64'd0);
        tick();
        bus.iValid = 1'b1;
        bus.iData  = 64'd7;
        #1;
        tick();
        bus.iValid = 1'b0;
        bus.iReady = 1'b0;
        // Re-set overflow by filling both banks is costly; use an in-block write count instead.
        do_reset();
        wr_block(50, 1'b1);
        n = 0;
        for (int c = 0; c < 50 && n < 5; c++) begin
            tick();
            bus.iValid = 1'b0;
            bus.iReady = 1'b1;
            #1;
            if (bus.oValid) n++;
        end
        chk("mid_outputs", 64'(n), 64'd5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ovalid", 64'(bus.oValid), 64'd0);
        chk("mid_rst_oready", 64'(bus.oReady), 64'd1);
        chk("mid_rst_ovf", 64'(bus.oOverflow), 64'd0);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            bus.iValid = 1'b1;
            bus.iData  = 64'(100 + i);
            bus.iReady = 1'b1;
            #1;
            if (i == 0) chk("mid_first_addr", 64'(bus.oRamAddr), 64'd0);
        end
        n = 0;
        for (int c = 0; c < 60 && n < 16; c++) begin
            tick();
            bus.iValid = 1'b0;
            bus.iReady = 1'b1;
            #1;
            if (bus.oValid) begin
                chk($sformatf("mid_out%0d", n), bus.oData, 64'(100 + idx(n)));
                chk($sformatf("mid_last%0d", n), 64'(bus.oLast), 64'(n == 15));
                n++;
            end
        end
        chk("mid_words", 64'(n), 64'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
